// File: rtl/delay_sched.sv
// delay_sched: converts a delay request given in time units (integer part plus a
// binary fraction) into precision ticks, counts it down and emits a one-cycle fire
// pulse when it expires. A free-running time base reports elapsed time units.
//
// Optional build macro: TIME_ROUND_EN
//   When defined, now_units rounds to the nearest unit using the sub-unit counter.
//   When undefined, now_units reports only completed units (truncated).

module delay_sched #(
    parameter int unsigned UNIT_RATIO = 1000,
    parameter int unsigned INT_W      = 16,
    parameter int unsigned FRAC_W     = 10,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [INT_W-1:0]  req_int,
    input  logic [FRAC_W-1:0] req_frac,
    input  logic              cancel,
    output logic              busy,
    output logic              fire,
    output logic              ovf,
    output logic [CNT_W-1:0]  remaining,
    output logic [CNT_W-1:0]  now_units
);

    // Widths for the conversion datapath. PROD_W covers the larger of the two
    // products plus the rounding carry; WIDE_W adds headroom so the saturation
    // compare against 2**CNT_W-1 is always meaningful.
    localparam int unsigned RATIO_W = $clog2(UNIT_RATIO + 1);
    localparam int unsigned PART_W  = (INT_W > FRAC_W) ? INT_W : FRAC_W;
    localparam int unsigned PROD_W  = PART_W + RATIO_W + 2;
    localparam int unsigned WIDE_W  = ((PROD_W > CNT_W) ? PROD_W : CNT_W) + 1;

    // Sub-unit counter width; keep at least one bit when UNIT_RATIO is 1.
    localparam int unsigned SUB_W = (UNIT_RATIO > 1) ? $clog2(UNIT_RATIO) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StCount,
        StFire
    } state_t;

    state_t              state_q, state_d;
    logic [INT_W-1:0]    int_q, int_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [CNT_W-1:0]    units_q, units_d;
    logic                sub_wrap;

    logic [WIDE_W-1:0]   ratio_wide;
    logic [WIDE_W-1:0]   int_prod;
    logic [WIDE_W-1:0]   frac_prod;
    logic [WIDE_W-1:0]   frac_half;
    logic [WIDE_W-1:0]   frac_ticks;
    logic [WIDE_W-1:0]   n_full;
    logic [WIDE_W-1:0]   cnt_max;
    logic                n_sat;
    logic [CNT_W-1:0]    n_ticks;

    // Tick conversion from the registered request: integer part scaled exactly,
    // fractional part scaled and rounded half up, then saturated to CNT_W bits.
    always_comb begin
        ratio_wide = WIDE_W'(UNIT_RATIO);
        int_prod   = WIDE_W'(int_q) * ratio_wide;
        frac_prod  = WIDE_W'(frac_q) * ratio_wide;
        frac_half  = WIDE_W'(1) << (FRAC_W - 1);
        frac_ticks = (frac_prod + frac_half) >> FRAC_W;
        n_full     = int_prod + frac_ticks;
        cnt_max    = {{(WIDE_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};
        n_sat      = (n_full > cnt_max);
        n_ticks    = n_sat ? {CNT_W{1'b1}} : n_full[CNT_W-1:0];
    end

    // FSM next state: request capture, load, countdown, fire and cancel handling.
    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                // A request beats a simultaneous cancel; cancel means nothing here.
                if (req_valid) begin
                    state_d = StCalc;
                    int_d   = req_int;
                    frac_d  = req_frac;
                    ovf_d   = 1'b0;
                end
            end
            StCalc: begin
                ovf_d = n_sat;
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    state_d = StCount;
                    cnt_d   = n_ticks;
                end
            end
            StCount: begin
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StFire;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StFire: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and request state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            int_q   <= '0;
            frac_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Time base next state: sub-unit counter wraps once per unit and bumps units.
    always_comb begin
        sub_wrap = (sub_q == SUB_W'(UNIT_RATIO - 1));
        sub_d    = sub_wrap ? '0 : sub_q + SUB_W'(1);
        units_d  = sub_wrap ? units_q + CNT_W'(1) : units_q;
    end

    // Time base registers; run on every edge regardless of FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q   <= '0;
            units_q <= '0;
        end else begin
            sub_q   <= sub_d;
            units_q <= units_d;
        end
    end

`ifdef TIME_ROUND_EN
    // Round to nearest unit: the half-way point is ceil(UNIT_RATIO/2) ticks.
    localparam int unsigned HALF_UNIT = (UNIT_RATIO + 1) / 2;

    logic round_up;

    // Rounded elapsed time, wrapping modulo 2**CNT_W like the unit counter.
    always_comb begin
        round_up  = (sub_q >= SUB_W'(HALF_UNIT));
        now_units = units_q + CNT_W'(round_up);
    end
`else
    // Truncated elapsed time: completed units only.
    always_comb begin
        now_units = units_q;
    end
`endif

    // Status outputs decoded from the current state.
    always_comb begin
        req_ready = (state_q == StIdle);
        busy      = (state_q == StCalc) || (state_q == StCount);
        fire      = (state_q == StFire);
        ovf       = ovf_q;
        remaining = (state_q == StCount) ? cnt_q : '0;
    end

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched. Three instances share clock and reset:
// the default configuration, an 8-bit counter that saturates, and a
// UNIT_RATIO=10 instance for time-base and rounding checks.

module tb_delay_sched;

`ifdef TIME_ROUND_EN
    localparam int unsigned ROUND_EXP = 4;
`else
    localparam int unsigned ROUND_EXP = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Default instance.
    logic        m_valid, m_cancel, m_ready, m_busy, m_fire, m_ovf;
    logic [15:0] m_int;
    logic [9:0]  m_frac;
    logic [31:0] m_rem, m_now;

    // CNT_W=8 instance.
    logic        s_valid, s_cancel, s_ready, s_busy, s_fire, s_ovf;
    logic [15:0] s_int;
    logic [9:0]  s_frac;
    logic [7:0]  s_rem, s_now;

    // UNIT_RATIO=10 instance.
    logic        r_valid, r_cancel, r_ready, r_busy, r_fire, r_ovf;
    logic [15:0] r_int;
    logic [9:0]  r_frac;
    logic [31:0] r_rem, r_now;

    delay_sched u_main (
        .clk(clk), .rst(rst), .req_valid(m_valid), .req_ready(m_ready),
        .req_int(m_int), .req_frac(m_frac), .cancel(m_cancel), .busy(m_busy),
        .fire(m_fire), .ovf(m_ovf), .remaining(m_rem), .now_units(m_now)
    );

    delay_sched #(.CNT_W(8)) u_sat (
        .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s_ready),
        .req_int(s_int), .req_frac(s_frac), .cancel(s_cancel), .busy(s_busy),
        .fire(s_fire), .ovf(s_ovf), .remaining(s_rem), .now_units(s_now)
    );

    delay_sched #(.UNIT_RATIO(10)) u_r10 (
        .clk(clk), .rst(rst), .req_valid(r_valid), .req_ready(r_ready),
        .req_int(r_int), .req_frac(r_frac), .cancel(r_cancel), .busy(r_busy),
        .fire(r_fire), .ovf(r_ovf), .remaining(r_rem), .now_units(r_now)
    );

    int tests = 0;
    int fails = 0;
    int k;
    int nf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic fire_of(input int which);
        case (which)
            0:       return m_fire;
            1:       return s_fire;
            default: return r_fire;
        endcase
    endfunction

    // Tick until the selected instance fires or the limit expires; cnt = ticks taken.
    task automatic wait_fire(input int which, input int limit, output int cnt);
        cnt = 0;
        while (cnt < limit) begin
            tick();
            cnt++;
            if (fire_of(which)) break;
        end
    endtask

    initial begin
        m_valid = 0; m_cancel = 0; m_int = 0; m_frac = 0;
        s_valid = 0; s_cancel = 0; s_int = 0; s_frac = 0;
        r_valid = 0; r_cancel = 0; r_int = 0; r_frac = 0;

        // Reset values while reset is held.
        #12;
        chk("rst_ready", m_ready, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_fire", m_fire, 0);
        chk("rst_ovf", m_ovf, 0);
        chk("rst_rem", m_rem, 0);
        chk("rst_now", m_now, 0);
        rst = 0;

        // Time base, UNIT_RATIO=10: 34 edges -> 3 units + 4; 35 edges -> 3 units + 5.
        repeat (34) tick();
        chk("r10_now_sub4", r_now, 3);
        tick();
        chk("r10_now_sub5", r_now, ROUND_EXP);
        chk("main_now_early", m_now, 0);

        // Half-up rounding: frac 256/1024 * 10 = 2.5 -> 3 ticks, fire at E0+5.
        r_valid = 1; r_int = 0; r_frac = 256;
        tick();
        r_valid = 0;
        chk("r10_calc_busy", r_busy, 1);
        chk("r10_calc_rem", r_rem, 0);
        tick();
        chk("r10_half_up_rem", r_rem, 3);
        wait_fire(2, 20, k);
        chk("r10_half_up_lat", k, 4);
        tick();
        // 1 + 255/1024 units -> 10 + 2.49 -> 12 ticks, fire at E0+14.
        r_valid = 1; r_int = 1; r_frac = 255;
        tick();
        r_valid = 0;
        tick();
        chk("r10_round_down_rem", r_rem, 12);
        wait_fire(2, 40, k);
        chk("r10_round_down_lat", k, 13);
        tick();

        // Main: 2 + 126/1024 units -> N = 2123, fire at E0+2125.
        m_valid = 1; m_int = 2; m_frac = 126;
        tick();
        m_valid = 0;
        chk("t1_calc_ready", m_ready, 0);
        chk("t1_calc_busy", m_busy, 1);
        chk("t1_calc_rem", m_rem, 0);
        tick();
        chk("t1_load_rem", m_rem, 2123);
        chk("t1_ovf", m_ovf, 0);
        wait_fire(0, 3000, k);
        chk("t1_latency", k, 2124);
        chk("t1_fire_busy", m_busy, 0);
        chk("t1_fire_ready", m_ready, 0);
        chk("t1_fire_now", m_now, 2);
        tick();
        chk("t1_pulse_width", m_fire, 0);
        chk("t1_idle_ready", m_ready, 1);

        // Zero delay: fire at E0+2, remaining stays 0.
        m_valid = 1; m_int = 0; m_frac = 0;
        tick();
        m_valid = 0;
        chk("t2_calc_busy", m_busy, 1);
        tick();
        chk("t2_count_busy", m_busy, 1);
        chk("t2_count_rem", m_rem, 0);
        chk("t2_count_fire", m_fire, 0);
        tick();
        chk("t2_fire", m_fire, 1);
        chk("t2_fire_busy", m_busy, 0);
        tick();
        chk("t2_after_fire", m_fire, 0);

        // Cancel during COUNT: N = 5000, cancel sampled at E0+101.
        m_valid = 1; m_int = 5; m_frac = 0;
        tick();
        m_valid = 0;
        repeat (100) tick();
        chk("t3_rem_e100", m_rem, 4901);
        m_cancel = 1;
        tick();
        m_cancel = 0;
        chk("t3_cancel_ready", m_ready, 1);
        chk("t3_cancel_busy", m_busy, 0);
        chk("t3_cancel_rem", m_rem, 0);
        nf = 0;
        repeat (5100) begin
            tick();
            if (m_fire) nf++;
        end
        chk("t3_no_fire", nf, 0);

        // Cancel together with a request in IDLE: the accept wins.
        m_valid = 1; m_cancel = 1; m_int = 0; m_frac = 0;
        tick();
        m_valid = 0; m_cancel = 0;
        chk("t3_accept_wins", m_busy, 1);
        tick();
        tick();
        chk("t3_accept_fire", m_fire, 1);
        tick();

        // Saturation, CNT_W=8: N = 1000 -> 255, fire at E0+257.
        s_valid = 1; s_int = 1; s_frac = 0;
        tick();
        s_valid = 0;
        chk("t4_calc_ovf", s_ovf, 0);
        tick();
        chk("t4_ovf", s_ovf, 1);
        chk("t4_rem", s_rem, 255);
        wait_fire(1, 400, k);
        chk("t4_latency", k, 256);
        chk("t4_ovf_sticky", s_ovf, 1);
        tick();
        s_valid = 1; s_int = 0; s_frac = 0;
        tick();
        s_valid = 0;
        chk("t4_ovf_clear", s_ovf, 0);
        repeat (3) tick();

        // Async reset mid-COUNT.
        m_valid = 1; m_int = 1; m_frac = 0;
        tick();
        m_valid = 0;
        repeat (50) tick();
        chk("t5_pre_busy", m_busy, 1);
        #2 rst = 1;
        #1;
        chk("t5_rst_ready", m_ready, 1);
        chk("t5_rst_busy", m_busy, 0);
        chk("t5_rst_fire", m_fire, 0);
        chk("t5_rst_rem", m_rem, 0);
        chk("t5_rst_now", m_now, 0);
        #3 rst = 0;
        nf = 0;
        repeat (1100) begin
            tick();
            if (m_fire) nf++;
        end
        chk("t5_no_fire", nf, 0);
        chk("t5_now_after", m_now, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
